btn_conditioner: RTL and testbench



---
 rtl/btn_pkg.sv | 10 +
 rtl/btn_conditioner_if.sv | 16 +
 rtl/btn_channel.sv | 89 ++++++++
 rtl/btn_conditioner.sv | 40 ++++
 tb/tb_btn_conditioner.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and tick arithmetic for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {RELEASED, PRESS_CHK, PRESSED, REL_CHK} btn_state_t;

    function automatic int unsigned ms_to_ticks(input int unsigned f_clk_hz, input int unsigned ms);
        return (f_clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// btn_conditioner_if: raw button inputs and conditioned outputs of the button conditioner
// btn_n: raw active-low buttons; level/press/rel/long_press/toggle: conditioned per-button outputs
interface btn_conditioner_if #(
    parameter int N_BTN = 3
);
    logic [N_BTN-1:0] btn_n;
    logic [N_BTN-1:0] level;
    logic [N_BTN-1:0] press;
    // release pulse; "release" itself is a reserved word
    logic [N_BTN-1:0] rel;
    logic [N_BTN-1:0] long_press;
    logic [N_BTN-1:0] toggle;

    modport master (output btn_n, input level, press, rel, long_press, toggle);
    modport slave  (input btn_n, output level, press, rel, long_press, toggle);
endinterface

// File: rtl/btn_channel.sv
// btn_channel: synchroniser, debounce FSM, hold timer and toggle latch for one button
// in: clk, reset, btn_n (raw, active-low); out: level, press, rel, long_press, toggle
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DB_TKS   = 20,
    parameter int unsigned LONG_TKS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic rel,
    output logic long_press,
    output logic toggle
);
    localparam int DB_W   = DB_TKS > 1 ? $clog2(DB_TKS) : 1;
    localparam int HOLD_W = LONG_TKS > 1 ? $clog2(LONG_TKS) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_TKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TKS - 1);

    logic [1:0]        sync_q, sync_d;
    btn_state_t        state_q, state_d;
    logic [DB_W-1:0]   db_q, db_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic fired_q, fired_d, level_q, level_d, press_q, press_d;
    logic rel_q, rel_d, long_q, long_d, toggle_q, toggle_d;
    logic s, held;

    assign s = ~sync_q[1];

    always_comb begin
        sync_d  = {sync_q[0], btn_n};
        held    = state_q == PRESSED || state_q == REL_CHK;
        state_d = state_q;
        db_d    = db_q;
        case (state_q)
            RELEASED:  if (s) begin state_d = PRESS_CHK; db_d = '0; end
            PRESS_CHK: if (!s) begin state_d = RELEASED; db_d = '0; end
                       else if (db_q == DB_LAST) state_d = PRESSED;
                       else db_d = db_q + 1'b1;
            PRESSED:   if (!s) begin state_d = REL_CHK; db_d = '0; end
            REL_CHK:   if (s) state_d = PRESSED;
                       else if (db_q == DB_LAST) state_d = RELEASED;
                       else db_d = db_q + 1'b1;
        endcase
        press_d  = state_q == PRESS_CHK && state_d == PRESSED;
        rel_d    = state_q == REL_CHK && state_d == RELEASED;
        level_d  = state_d == PRESSED || state_d == REL_CHK;
        toggle_d = toggle_q ^ press_d;
        // hold_cnt keeps running through release glitches so a press yields one long pulse
        hold_d   = press_d ? '0 : (held && hold_q != HOLD_LAST) ? hold_q + 1'b1 : hold_q;
        long_d   = held && hold_q == HOLD_LAST && !fired_q;
        fired_d  = press_d ? 1'b0 : fired_q | long_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b11;
            state_q  <= RELEASED;
            db_q     <= '0;
            hold_q   <= '0;
            fired_q  <= 1'b0;
            level_q  <= 1'b0;
            press_q  <= 1'b0;
            rel_q    <= 1'b0;
            long_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            db_q     <= db_d;
            hold_q   <= hold_d;
            fired_q  <= fired_d;
            level_q  <= level_d;
            press_q  <= press_d;
            rel_q    <= rel_d;
            long_q   <= long_d;
            toggle_q <= toggle_d;
        end
    end

    assign level      = level_q;
    assign press      = press_q;
    assign rel        = rel_q;
    assign long_press = long_q;
    assign toggle     = toggle_q;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: debounces N_BTN raw active-low buttons into levels, pulses and toggles
// in: clk, reset; bus (slave): btn_n in, level/press/rel/long_press/toggle out
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned F_CLK_HZ    = 25_000_000,
    parameter int unsigned N_BTN       = 3,
    parameter int unsigned DEBOUNCE_MS = 20,
    parameter int unsigned LONG_MS     = 1000
) (
    input logic clk,
    input logic reset,
    btn_conditioner_if.slave bus
);
    localparam int unsigned DB_TKS   = ms_to_ticks(F_CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_TKS = ms_to_ticks(F_CLK_HZ, LONG_MS);

    if (DB_TKS == 0) begin : g_bad_db
        $error("btn_conditioner: debounce time is zero ticks");
    end
    if (LONG_TKS <= DB_TKS) begin : g_bad_long
        $error("btn_conditioner: long-press time must exceed debounce time");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DB_TKS  (DB_TKS),
            .LONG_TKS(LONG_TKS)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn_n     (bus.btn_n[i]),
            .level     (bus.level[i]),
            .press     (bus.press[i]),
            .rel       (bus.rel[i]),
            .long_press(bus.long_press[i]),
            .toggle    (bus.toggle[i])
        );
    end
endmodule

// File: tb/tb_btn_conditioner.sv
// tb_btn_conditioner: directed and random checks of btn_conditioner against a run-length reference model
module tb_btn_conditioner;
    localparam int DB_TKS   = 4;
    localparam int LONG_TKS = 20;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    btn_conditioner_if #(.N_BTN(3)) bus ();

    btn_conditioner #(
        .F_CLK_HZ   (1000),
        .N_BTN      (3),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: a level change is accepted once the synchronised sample has disagreed with
    // the accepted level for DB_TKS+1 consecutive clocks; long press when the accepted press
    // has lasted exactly LONG_TKS clocks.
    logic [2:0] m_sy0 = '1, m_sy1 = '1, m_lvl = '0, m_prs = '0, m_rls = '0, m_lng = '0, m_tog = '0;
    int m_run [3] = '{default: 0};
    int m_hold [3] = '{default: 0};

    always @(posedge clk) begin : model
        logic [2:0] sy0, sy1, lvl, prs, rls, lng, tog;
        int run [3];
        int hold [3];
        sy0 = m_sy0; sy1 = m_sy1; lvl = m_lvl; tog = m_tog; run = m_run; hold = m_hold;
        prs = '0; rls = '0; lng = '0;
        if (reset) begin
            sy0 = '1; sy1 = '1; lvl = '0; tog = '0;
            run = '{default: 0};
            hold = '{default: 0};
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (lvl[c]) begin
                    hold[c]++;
                    if (hold[c] == LONG_TKS) lng[c] = 1'b1;
                end
                run[c] = ((!sy1[c]) != lvl[c]) ? run[c] + 1 : 0;
                if (run[c] == DB_TKS + 1) begin
                    run[c] = 0;
                    lvl[c] = !lvl[c];
                    if (lvl[c]) begin
                        prs[c] = 1'b1;
                        tog[c] = !tog[c];
                        hold[c] = 0;
                    end else rls[c] = 1'b1;
                end
                sy1[c] = sy0[c];
                sy0[c] = bus.btn_n[c];
            end
        end
        m_sy0 <= sy0; m_sy1 <= sy1; m_lvl <= lvl; m_prs <= prs; m_rls <= rls;
        m_lng <= lng; m_tog <= tog; m_run <= run; m_hold <= hold;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("m_level", bus.level, m_lvl);
            check("m_press", bus.press, m_prs);
            check("m_release", bus.rel, m_rls);
            check("m_long", bus.long_press, m_lng);
            check("m_toggle", bus.toggle, m_tog);
        end
    end

    initial begin
        int cnt_p, cnt_l, cnt_r;
        bus.btn_n = '1;
        reset = 1'b1;
        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_level", bus.level, 0);
        check("rst_toggle", bus.toggle, 0);
        check("rst_pulses", {bus.press, bus.rel, bus.long_press}, 0);
        reset = 1'b0;

        // clean press on channel 0
        bus.btn_n[0] = 1'b0;
        repeat (6) @(negedge clk);
        check("press_early", bus.press, 0);
        @(negedge clk);
        check("press_at7", bus.press, 3'b001);
        check("press_level", bus.level, 3'b001);
        check("press_toggle", bus.toggle, 3'b001);
        @(negedge clk);
        check("press_width", bus.press, 0);

        // release
        repeat (10) @(negedge clk);
        bus.btn_n[0] = 1'b1;
        repeat (6) @(negedge clk);
        check("rel_early", bus.rel, 0);
        @(negedge clk);
        check("rel_at7", bus.rel, 3'b001);
        check("rel_level", bus.level, 0);

        // bounce: low 3, high 1, then steady low
        repeat (5) @(negedge clk);
        bus.btn_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        bus.btn_n[0] = 1'b1;
        @(negedge clk);
        bus.btn_n[0] = 1'b0;
        cnt_p = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            cnt_p += int'(bus.press[0]);
            if (n == 7) check("bounce_at7", bus.press[0], 1);
        end
        check("bounce_count", cnt_p, 1);
        check("toggle_back", bus.toggle[0], 0);
        bus.btn_n[0] = 1'b1;
        repeat (12) @(negedge clk);

        // long press on channel 1 with a 2-cycle release glitch
        bus.btn_n[1] = 1'b0;
        cnt_l = 0;
        cnt_r = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            cnt_l += int'(bus.long_press[1]);
            cnt_r += int'(bus.rel[1]);
            if (n == 7) check("long_press_at7", bus.press, 3'b010);
            if (n == 26) check("long_early", bus.long_press, 0);
            if (n == 27) check("long_at27", bus.long_press, 3'b010);
            if (n == 36) check("glitch_no_rel", cnt_r, 0);
            if (n == 37) check("long_rel_at37", bus.rel, 3'b010);
            if (n == 12) bus.btn_n[1] = 1'b1;
            if (n == 14) bus.btn_n[1] = 1'b0;
            if (n == 30) bus.btn_n[1] = 1'b1;
        end
        check("long_count", cnt_l, 1);
        check("long_rel_count", cnt_r, 1);

        // simultaneous press on channels 0 and 2
        repeat (5) @(negedge clk);
        bus.btn_n = 3'b010;
        repeat (6) @(negedge clk);
        check("simul_early", bus.press, 0);
        @(negedge clk);
        check("simul_press", bus.press, 3'b101);
        bus.btn_n = '1;
        repeat (12) @(negedge clk);

        // reset while channel 0 is held
        bus.btn_n[0] = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_level", bus.level, 3'b001);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_level", bus.level, 0);
        check("mid_rst_toggle", bus.toggle, 0);
        check("mid_rst_pulses", {bus.press, bus.rel, bus.long_press}, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("repress_early", bus.press, 0);
        @(negedge clk);
        check("repress_at7", bus.press, 3'b001);
        bus.btn_n[0] = 1'b1;
        repeat (12) @(negedge clk);

        // random traffic alternating between bouncy and slow phases
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            reset = $urandom_range(0, 299) == 0;
            for (int c = 0; c < 3; c++)
                if ($urandom_range(0, ((i / 100) % 2 == 1) ? 39 : 4) == 0) bus.btn_n[c] = !bus.btn_n[c];
        end
        reset = 1'b0;
        bus.btn_n = '1;
        repeat (10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
